regfile_wb_arbiter: RTL

- Writeback controller for the 16x16 register file. It shares the file's single write port between two requesters: the ALU result path and the load unit.
- Round-robin arbitration, valid/ready handshakes and a registered write stage drive the register file's write_en/rd/data_in.
- Keeps a pending-write scoreboard (busy_mask) that decode uses for RAW stall decisions.
- Sits between execute/memory stages and the register file write port.

---
 rtl/regfile_wb_arbiter_if.sv | 44 ++++
 rtl/regfile_wb_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the execute/memory requesters, decode and the arbiter.
// Carries the ALU and load valid/ready requests, the decode issue strobe, and
// the registered register-file write port plus scoreboard and arbitration state.
//   slave  : arbiter side (drives readies, rf_* write port, busy_mask, last_grant)
//   master : requester/decode side (drives valids, rd/data, issue_en/issue_rd)
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NREG   = 16
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_rd;
  logic              rf_write_en;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_data;
  logic [NREG-1:0]   busy_mask;
  logic              last_grant;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  issue_en, issue_rd,
    output alu_ready, ld_ready,
    output rf_write_en, rf_rd, rf_data,
    output busy_mask, last_grant
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output issue_en, issue_rd,
    input  alu_ready, ld_ready,
    input  rf_write_en, rf_rd, rf_data,
    input  busy_mask, last_grant
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Writeback controller for the register file's single write port.
// Round-robin arbitrates between the ALU and load unit, registers the winning
// write for one cycle in front of the register file, and maintains the
// pending-write scoreboard (busy_mask) used by decode for RAW stalls.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : regfile_wb_arbiter_if.slave (requests, issue strobe, rf write port,
//          busy_mask, last_grant; readies are combinational, the rest registered)
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NREG   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  // Arbitration state equals last_grant: 1 = load won last (ALU has priority).
  localparam logic [0:0] PRI_LD  = 1'b0;
  localparam logic [0:0] PRI_ALU = 1'b1;

  logic [0:0]        last_grant_q, last_grant_d;
  logic              rf_write_en_q, rf_write_en_d;
  logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              alu_grant_c, ld_grant_c;

  // Arbitration: readies and next priority state.
  always_comb begin
    alu_grant_c  = 1'b0;
    ld_grant_c   = 1'b0;
    last_grant_d = last_grant_q;
    if (!rst) begin
      if (last_grant_q == PRI_ALU) begin
        if (bus.alu_valid)     alu_grant_c = 1'b1;
        else if (bus.ld_valid) ld_grant_c  = 1'b1;
      end else begin
        if (bus.ld_valid)       ld_grant_c  = 1'b1;
        else if (bus.alu_valid) alu_grant_c = 1'b1;
      end
    end
    if (alu_grant_c)     last_grant_d = PRI_LD;
    else if (ld_grant_c) last_grant_d = PRI_ALU;
  end

  // Write stage and scoreboard next state.
  always_comb begin
    rf_write_en_d = 1'b0;
    rf_rd_d       = rf_rd_q;
    rf_data_d     = rf_data_q;
    busy_d        = busy_q;
    if (alu_grant_c) begin
      rf_rd_d       = bus.alu_rd;
      rf_data_d     = bus.alu_data;
      rf_write_en_d = (bus.alu_rd != '0);
    end else if (ld_grant_c) begin
      rf_rd_d       = bus.ld_rd;
      rf_data_d     = bus.ld_data;
      rf_write_en_d = (bus.ld_rd != '0);
    end
    // Clear first so a same-register reservation in this cycle wins.
    if (rf_write_en_q) busy_d[rf_rd_q] = 1'b0;
    if (bus.issue_en && (bus.issue_rd != '0)) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q  <= PRI_ALU;
      rf_write_en_q <= 1'b0;
      rf_rd_q       <= '0;
      rf_data_q     <= '0;
      busy_q        <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      rf_write_en_q <= rf_write_en_d;
      rf_rd_q       <= rf_rd_d;
      rf_data_q     <= rf_data_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.alu_ready   = alu_grant_c;
  assign bus.ld_ready    = ld_grant_c;
  assign bus.rf_write_en = rf_write_en_q;
  assign bus.rf_rd       = rf_rd_q;
  assign bus.rf_data     = rf_data_q;
  assign bus.busy_mask   = busy_q;
  assign bus.last_grant  = last_grant_q[0];

endmodule
